// File: rtl/spi_slave_regfile_if.sv
// spi_slave_regfile_if: SPI pins and fabric-side register file view of the SPI responder
interface spi_slave_regfile_if #(
    parameter int NUM_REGS = 8
);
    logic                    spi_sclk;
    logic                    spi_ss_n;
    logic                    spi_mosi;
    logic                    spi_miso;
    logic                    spi_miso_oe;
    logic [8*NUM_REGS-1:0]   regs_out;
    logic                    wr_stb;
    logic [6:0]              wr_addr;
    logic [7:0]              wr_data;
    logic                    busy;
    logic                    frame_err;

    modport slave (
        input  spi_sclk, spi_ss_n, spi_mosi,
        output spi_miso, spi_miso_oe, regs_out, wr_stb, wr_addr, wr_data, busy, frame_err
    );

    modport master (
        output spi_sclk, spi_ss_n, spi_mosi,
        input  spi_miso, spi_miso_oe, regs_out, wr_stb, wr_addr, wr_data, busy, frame_err
    );
endinterface

// File: rtl/spi_slave_regfile.sv
// spi_slave_regfile: oversampled mode-0 SPI responder exposing a byte-wide register file
module spi_slave_regfile #(
    parameter int         NUM_REGS    = 8,
    parameter logic [7:0] ID_VALUE    = 8'h5A,
    parameter int         SYNC_STAGES = 2
) (
    input logic                clk,
    input logic                rst,
    spi_slave_regfile_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CMD, DATA, ABORT} state_t;

    localparam int         AW     = $clog2(NUM_REGS);
    localparam logic [7:0] NR     = 8'(NUM_REGS);
    localparam logic [2:0] SETTLE = 3'(SYNC_STAGES + 1);

    state_t                 state, state_nxt;
    logic [SYNC_STAGES:0]   sclk_p, ss_p;
    logic [SYNC_STAGES-1:0] mosi_p;
    logic                   sclk_rise, sclk_fall, ss_rise, ss_fall, ss_s, mosi_s;
    logic [2:0]             bit_cnt, settle;
    logic [6:0]             rx_shift, addr, rd_sel;
    logic [7:0]             tx_shift, rx_byte, rd_byte;
    logic                   is_wr, start, cmd_done, data_done, err, byte_done, active, wr_ok;
    logic [7:0]             regs [NUM_REGS];

    assign sclk_rise = sclk_p[SYNC_STAGES-1] & ~sclk_p[SYNC_STAGES];
    assign sclk_fall = ~sclk_p[SYNC_STAGES-1] & sclk_p[SYNC_STAGES];
    assign ss_s      = ss_p[SYNC_STAGES-1];
    assign ss_rise   = ss_s & ~ss_p[SYNC_STAGES];
    assign ss_fall   = ~ss_s & ss_p[SYNC_STAGES];
    assign mosi_s    = mosi_p[SYNC_STAGES-1];
    assign byte_done = sclk_rise & (bit_cnt == 3'd7);
    assign rx_byte   = {rx_shift, mosi_s};
    assign active    = (state == CMD) || (state == DATA);
    // The command byte supplies the first read address; later prefetches use the running address
    assign rd_sel    = (state == CMD) ? rx_byte[6:0] : addr;
    assign rd_byte   = ({1'b0, rd_sel} < NR) ? regs[rd_sel[AW-1:0]] : 8'h00;
    assign wr_ok     = (addr != 7'd0) && ({1'b0, addr} < NR);

    assign bus.spi_miso    = tx_shift[7];
    assign bus.spi_miso_oe = active;
    assign bus.busy        = state != IDLE;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        assign bus.regs_out[8*g +: 8] = regs[g];
    end

    // Synchronize the SPI pins and keep a post-reset window in which a low SS_N means a frame was cut
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_p <= '0;
            ss_p   <= '1;
            mosi_p <= '0;
            settle <= SETTLE;
        end else begin
            sclk_p <= {sclk_p[SYNC_STAGES-1:0], bus.spi_sclk};
            ss_p   <= {ss_p[SYNC_STAGES-1:0], bus.spi_ss_n};
            mosi_p <= {mosi_p[SYNC_STAGES-2:0], bus.spi_mosi};
            if (settle != 3'd0) settle <= settle - 3'd1;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and per-cycle control strobes; a byte completing with SS_N rising is committed, not flagged
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        cmd_done  = 1'b0;
        data_done = 1'b0;
        err       = 1'b0;
        case (state)
            IDLE: begin
                if (ss_fall) state_nxt = (settle != 3'd0) ? ABORT : CMD;
                start = ss_fall && (settle == 3'd0);
            end
            CMD, DATA: begin
                cmd_done  = byte_done && (state == CMD);
                data_done = byte_done && (state == DATA);
                if (byte_done) state_nxt = DATA;
                if (ss_rise) state_nxt = IDLE;
                err = ss_rise && !byte_done && (bit_cnt != 3'd0);
            end
            default: if (ss_s) state_nxt = IDLE;
        endcase
    end

    // Shift registers, address pointer, register file and fabric-side write reporting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt       <= '0;
            rx_shift      <= '0;
            tx_shift      <= '0;
            addr          <= '0;
            is_wr         <= 1'b0;
            bus.wr_stb    <= 1'b0;
            bus.wr_addr   <= '0;
            bus.wr_data   <= '0;
            bus.frame_err <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= (i == 0) ? ID_VALUE : 8'h00;
        end else begin
            bus.wr_stb    <= 1'b0;
            bus.frame_err <= err;
            if (sclk_rise) begin
                bit_cnt  <= bit_cnt + 3'd1;
                rx_shift <= rx_byte[6:0];
            end
            if (active && sclk_fall && bit_cnt != 3'd0) tx_shift <= {tx_shift[6:0], 1'b0};
            if (start) begin
                bit_cnt  <= '0;
                tx_shift <= '0;
            end
            if (cmd_done) begin
                is_wr <= rx_byte[7];
                addr  <= rx_byte[6:0] + {6'd0, ~rx_byte[7]};
                if (!rx_byte[7]) tx_shift <= rd_byte;
            end
            if (data_done) begin
                addr <= addr + 7'd1;
                if (!is_wr) begin
                    tx_shift <= rd_byte;
                end else if (wr_ok) begin
                    regs[addr[AW-1:0]] <= rx_byte;
                    bus.wr_stb         <= 1'b1;
                    bus.wr_addr        <= addr;
                    bus.wr_data        <= rx_byte;
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_slave_regfile.sv
// tb_spi_slave_regfile: randomized SPI frames checked against a frame-level register file model
module tb_spi_slave_regfile;
    localparam int NR   = 8;
    localparam int HALF = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_slave_regfile_if #(.NUM_REGS(NR)) bus ();
    spi_slave_regfile #(.NUM_REGS(NR), .ID_VALUE(8'h5A), .SYNC_STAGES(2)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int          total = 0;
    int          bad   = 0;
    int          stb_hi = 0;
    int          fe_hi  = 0;
    logic        stb_prev = 1'b0;
    logic [7:0]  mregs [NR];
    logic [15:0] wq[$];
    logic [15:0] eq[$];
    logic [7:0]  tx_q[$];
    logic [7:0]  rx_q[$];

    // Record each write pulse once and count how many cycles write/error strobes stay high
    always @(negedge clk) begin
        if (bus.wr_stb) stb_hi++;
        if (bus.wr_stb && !stb_prev) wq.push_back({1'b0, bus.wr_addr, bus.wr_data});
        stb_prev = bus.wr_stb;
        if (bus.frame_err) fe_hi++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic xfer_bits(input logic [7:0] b, input int nbits, output logic [7:0] r);
        r = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            bus.spi_mosi = b[i];
            wait_clks(HALF);
            r[i] = bus.spi_miso;
            bus.spi_sclk = 1'b1;
            wait_clks(HALF);
            bus.spi_sclk = 1'b0;
        end
    endtask

    task automatic mreset();
        for (int k = 0; k < NR; k++) mregs[k] = (k == 0) ? 8'h5A : 8'h00;
    endtask

    function automatic logic [7:0] mread(input logic [6:0] a);
        return (int'(a) < NR) ? mregs[a[2:0]] : 8'h00;
    endfunction

    function automatic logic [63:0] mflat();
        logic [63:0] f;
        for (int k = 0; k < NR; k++) f[8*k +: 8] = mregs[k];
        return f;
    endfunction

    task automatic run_frame(input string tag);
        logic [7:0] r;
        logic [7:0] exp;
        logic [6:0] a;
        wq.delete();
        eq.delete();
        rx_q.delete();
        stb_hi = 0;
        fe_hi  = 0;
        bus.spi_ss_n = 1'b0;
        wait_clks(HALF);
        check({tag, " busy_mid"}, bus.busy, 1);
        check({tag, " oe_mid"}, bus.spi_miso_oe, 1);
        foreach (tx_q[j]) begin
            xfer_bits(tx_q[j], 8, r);
            rx_q.push_back(r);
        end
        wait_clks(HALF);
        bus.spi_ss_n = 1'b1;
        wait_clks(HALF);
        a = tx_q[0][6:0];
        check({tag, " miso0"}, rx_q[0], 0);
        for (int j = 1; j < tx_q.size(); j++) begin
            exp = 8'h00;
            if (tx_q[0][7]) begin
                if (a != 7'd0 && int'(a) < NR) begin
                    mregs[a[2:0]] = tx_q[j];
                    eq.push_back({1'b0, a, tx_q[j]});
                end
            end else begin
                exp = mread(a);
            end
            check($sformatf("%s miso%0d", tag, j), rx_q[j], exp);
            a = a + 7'd1;
        end
        check({tag, " stb_cycles"}, stb_hi, eq.size());
        check({tag, " stb_count"}, wq.size(), eq.size());
        foreach (eq[j]) if (j < wq.size()) check($sformatf("%s wr%0d", tag, j), wq[j], eq[j]);
        check({tag, " frame_err"}, fe_hi, 0);
        check({tag, " busy_end"}, bus.busy, 0);
        check({tag, " regs"}, bus.regs_out, mflat());
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] r;
        logic [6:0] a;
        int         p;
        int         len;
        bus.spi_sclk = 1'b0;
        bus.spi_ss_n = 1'b1;
        bus.spi_mosi = 1'b0;
        wait_clks(4);
        rst = 1'b0;
        wait_clks(6);
        mreset();
        check("rst regs", bus.regs_out, mflat());
        check("rst oe", bus.spi_miso_oe, 0);
        check("rst busy", bus.busy, 0);
        check("rst miso", bus.spi_miso, 0);
        check("rst wr_stb", bus.wr_stb, 0);
        check("rst wr_addr", bus.wr_addr, 0);
        check("rst wr_data", bus.wr_data, 0);
        check("rst frame_err", bus.frame_err, 0);

        tx_q = '{8'h82, 8'h11, 8'h22, 8'h33};
        run_frame("burst");
        check("burst reg2", bus.regs_out[23:16], 8'h11);
        check("burst reg3", bus.regs_out[31:24], 8'h22);
        check("burst reg4", bus.regs_out[39:32], 8'h33);

        tx_q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00};
        run_frame("rd2");
        check("rd2 b1", rx_q[1], 8'h11);
        check("rd2 b2", rx_q[2], 8'h22);
        check("rd2 b3", rx_q[3], 8'h33);
        check("rd2 b4", rx_q[4], 8'h00);

        tx_q = '{8'h00, 8'h00};
        run_frame("rd_id");
        check("rd_id b1", rx_q[1], 8'h5A);

        tx_q = '{8'h80, 8'hFF};
        run_frame("wr_id");
        check("wr_id nostb", wq.size(), 0);
        check("wr_id reg0", bus.regs_out[7:0], 8'h5A);

        tx_q = '{8'h0A, 8'h00};
        run_frame("rd_oob");
        check("rd_oob b1", rx_q[1], 8'h00);

        for (int n = 0; n < 25; n++) begin
            p   = $urandom_range(0, 13);
            a   = (p < 12) ? 7'(p) : 7'(p + 114);
            len = $urandom_range(1, 4);
            tx_q.delete();
            tx_q.push_back({1'($urandom_range(0, 1)), a});
            for (int j = 0; j < len; j++) tx_q.push_back(8'($urandom));
            run_frame($sformatf("rand%0d", n));
        end

        wq.delete();
        stb_hi = 0;
        fe_hi  = 0;
        bus.spi_ss_n = 1'b0;
        wait_clks(HALF);
        xfer_bits(8'h83, 8, r);
        xfer_bits(8'hAB, 5, r);
        wait_clks(HALF);
        bus.spi_ss_n = 1'b1;
        wait_clks(2 * HALF);
        check("ferr pulse", fe_hi, 1);
        check("ferr nostb", stb_hi, 0);
        check("ferr regs", bus.regs_out, mflat());
        check("ferr busy", bus.busy, 0);
        tx_q = '{8'h83, 8'h5C};
        run_frame("after_ferr");

        wq.delete();
        stb_hi = 0;
        bus.spi_ss_n = 1'b0;
        wait_clks(HALF);
        xfer_bits(8'h84, 3, r);
        rst = 1'b1;
        wait_clks(3);
        rst = 1'b0;
        wait_clks(8);
        mreset();
        check("abort busy", bus.busy, 1);
        check("abort oe", bus.spi_miso_oe, 0);
        xfer_bits(8'hFF, 5, r);
        xfer_bits(8'h77, 8, r);
        check("abort nostb", stb_hi, 0);
        check("abort regs", bus.regs_out, mflat());
        check("abort oe2", bus.spi_miso_oe, 0);
        bus.spi_ss_n = 1'b1;
        wait_clks(HALF);
        check("abort idle", bus.busy, 0);
        tx_q = '{8'h83, 8'h44};
        run_frame("post_abort");
        check("post_abort reg3", bus.regs_out[31:24], 8'h44);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
